// File: rtl/typing_round_ctrl.sv
// Typing-test round controller: debounces keypad presses, matches them against a 4-digit
// target word, counts score/misses and runs the round timer. Optional macro: MISS_PENALTY_EN.
module typing_round_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned ROUND_SECS      = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       one_hz_clk,
    input  logic       start,
    input  logic       key_level,
    input  logic [3:0] key_code,
    input  logic [3:0] rand_one,
    input  logic [3:0] rand_two,
    input  logic [3:0] rand_three,
    input  logic [3:0] rand_four,
    output logic [3:0] digit_one,
    output logic [3:0] digit_two,
    output logic [3:0] digit_three,
    output logic [3:0] digit_four,
    output logic       one_en,
    output logic       two_en,
    output logic       three_en,
    output logic       four_en,
    output logic [7:0] score,
    output logic [7:0] misses,
    output logic [5:0] secs_left,
    output logic       done
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [5:0]       SECS_INIT = 6'(ROUND_SECS);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

    state_t state_q, state_d;

    logic key_s1, key_s2;
    logic hz_s1, hz_s2, hz_d;
    logic st_s1, st_s2, st_d;
    logic hz_edge, start_edge;

    logic             deb_pressed;
    logic [CNT_W-1:0] deb_cnt;
    logic             press;
    logic [3:0]       key_cap;

    logic [3:0][3:0] dig_q, dig_d;
    logic [3:0]      en_q, en_d;
    logic [7:0]      score_q, score_d;
    logic [7:0]      misses_q, misses_d;
    logic [5:0]      secs_q, secs_d;
    logic [1:0]      pos_q, pos_d;
    logic            done_q, done_d;
    logic [1:0]      dec;

    // Two-flop synchronisers plus one extra stage for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_s1 <= 1'b0;
            key_s2 <= 1'b0;
            hz_s1  <= 1'b0;
            hz_s2  <= 1'b0;
            hz_d   <= 1'b0;
            st_s1  <= 1'b0;
            st_s2  <= 1'b0;
            st_d   <= 1'b0;
        end else begin
            key_s1 <= key_level;
            key_s2 <= key_s1;
            hz_s1  <= one_hz_clk;
            hz_s2  <= hz_s1;
            hz_d   <= hz_s2;
            st_s1  <= start;
            st_s2  <= st_s1;
            st_d   <= st_s2;
        end
    end

    assign hz_edge    = hz_s2 & ~hz_d;
    assign start_edge = st_s2 & ~st_d;

    // Debouncer: level must differ from the accepted state for DEBOUNCE_CYCLES in a row
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb_pressed <= 1'b0;
            deb_cnt     <= '0;
            press       <= 1'b0;
            key_cap     <= 4'h0;
        end else begin
            press <= 1'b0;
            if (key_s2 != deb_pressed) begin
                if (deb_cnt == CNT_LAST) begin
                    deb_pressed <= key_s2;
                    deb_cnt     <= '0;
                    if (key_s2) begin
                        press   <= 1'b1;
                        key_cap <= key_code;
                    end
                end else begin
                    deb_cnt <= deb_cnt + CNT_W'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dig_q    <= '0;
            en_q     <= 4'h0;
            score_q  <= 8'h00;
            misses_q <= 8'h00;
            secs_q   <= SECS_INIT;
            pos_q    <= 2'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dig_q    <= dig_d;
            en_q     <= en_d;
            score_q  <= score_d;
            misses_q <= misses_d;
            secs_q   <= secs_d;
            pos_q    <= pos_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dig_d    = dig_q;
        en_d     = en_q;
        score_d  = score_q;
        misses_d = misses_q;
        secs_d   = secs_q;
        pos_d    = pos_q;
        dec      = 2'd0;

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d  = LOAD;
                    score_d  = 8'h00;
                    misses_d = 8'h00;
                    secs_d   = SECS_INIT;
                end
            end
            LOAD: begin
                dig_d   = {rand_four, rand_three, rand_two, rand_one};
                en_d    = 4'hF;
                pos_d   = 2'd0;
                state_d = PLAY;
                if (hz_edge) begin
                    if (secs_q <= 6'd1) begin
                        secs_d  = 6'd0;
                        state_d = DONE;
                    end else begin
                        secs_d = secs_q - 6'd1;
                    end
                end
            end
            PLAY: begin
                // Expiry on the final tick swallows any coincident press
                if (hz_edge && secs_q == 6'd1) begin
                    secs_d  = 6'd0;
                    state_d = DONE;
                end else begin
                    dec = {1'b0, hz_edge};
                    if (press) begin
                        if (key_cap == dig_q[pos_q]) begin
                            en_d[pos_q] = 1'b0;
                            if (pos_q == 2'd3) begin
                                score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                                state_d = LOAD;
                            end else begin
                                pos_d = pos_q + 2'd1;
                            end
                        end else begin
                            misses_d = (misses_q == 8'hFF) ? misses_q : misses_q + 8'd1;
`ifdef MISS_PENALTY_EN
                            dec = dec + 2'd1;
`endif
                        end
                    end
                    if (6'(dec) >= secs_q) begin
                        secs_d  = 6'd0;
                        state_d = DONE;
                    end else begin
                        secs_d = secs_q - 6'(dec);
                    end
                end
            end
            DONE: begin
                if (start_edge) begin
                    state_d  = LOAD;
                    score_d  = 8'h00;
                    misses_d = 8'h00;
                    secs_d   = SECS_INIT;
                end
            end
            default: state_d = IDLE;
        endcase

        // Final score display, held for as long as the round stays finished
        done_d = (state_d == DONE);
        if (done_d) begin
            dig_d = {score_d[3:0], score_d[7:4], 4'h0, 4'h0};
            en_d  = 4'hF;
        end
    end

    assign digit_one   = dig_q[0];
    assign digit_two   = dig_q[1];
    assign digit_three = dig_q[2];
    assign digit_four  = dig_q[3];
    assign one_en      = en_q[0];
    assign two_en      = en_q[1];
    assign three_en    = en_q[2];
    assign four_en     = en_q[3];
    assign score       = score_q;
    assign misses      = misses_q;
    assign secs_left   = secs_q;
    assign done        = done_q;

endmodule

// File: doc/typing_round_ctrl.md
Name: typing_round_ctrl

Overview:
Game controller between the keypad decoder and the 4-digit seven-segment display in the typing test.
- Debounces the decoder's key-pressed level into single key events.
- Latches a 4-digit target word from the random generator and checks typed keys against it in order.
- Blanks each digit as it is matched and counts completed words and misses.
- Runs a countdown in seconds from the 1 Hz divider output, then shows the final score on the display.

Parameters:
DEBOUNCE_CYCLES, 1000000, clk cycles key level must be stable to register a press or release (10 ms at 100 MHz)
ROUND_SECS, 30, round length in seconds (1..63)

Ports:
clk  in  1  system clock (100 MHz)
rst_n  in  1  synchronous active-low reset
one_hz_clk  in  1  1 Hz square wave from clock divider; sampled as data, rising edge detected internally
start  in  1  level; rising edge starts a round
key_level  in  1  decoder button-pressed level
key_code  in  4  decoder key value (0x0-0xF)
rand_one, rand_two, rand_three, rand_four  in  4 each  random target digits
digit_one, digit_two, digit_three, digit_four  out  4 each  display digit values
one_en, two_en, three_en, four_en  out  1 each  display digit enables
score  out  8  words completed, saturates at 255
misses  out  8  wrong keys, saturates at 255
secs_left  out  6  seconds remaining
done  out  1  high in DONE state

Behaviour:
Reset (rst_n=0 at a clk edge):
- state=IDLE; all digits=0; all enables=0; score=0; misses=0; secs_left=ROUND_SECS; done=0.
- Debouncer returns to released state; position pointer pos=0.

Input synchronisation:
- key_level, one_hz_clk and start each pass through a 2-flop synchroniser.
- Rising edges are detected on the synchronised start and one_hz_clk signals.

Debouncer:
- The synchronised key_level must be high for DEBOUNCE_CYCLES consecutive cycles. On that cycle, a one-cycle press pulse is issued and key_code is captured.
- No further press is accepted until key_level has been low for DEBOUNCE_CYCLES consecutive cycles.
- Any glitch restarts the count.

FSM states: IDLE, LOAD, PLAY, DONE.
- IDLE: start edge -> LOAD; score=0, misses=0, secs_left=ROUND_SECS.
- LOAD (1 cycle):
  - Latch rand_one..four into digit_one..four.
  - Set all enables to 1 and pos=0.
  - Go to PLAY.
- PLAY, press pulse with key_code == digit[pos]:
  - Clear enable[pos] (digit blanked from the next cycle).
  - If pos=3: score+1 (saturating) and go to LOAD; otherwise pos+1.
- PLAY, press pulse with key_code != digit[pos]: misses+1 (saturating); pos unchanged.
- PLAY or LOAD, one_hz edge: secs_left-1.
  - When secs_left is 1 and a tick arrives, secs_left=0 and the state goes to DONE.
- DONE:
  - digit_one=0, digit_two=0, digit_three=score[7:4], digit_four=score[3:0]; all enables=1; done=1.
  - Start edge -> LOAD with score, misses and secs_left reinitialised.

Boundary rules:
- Timer expiry and a press in the same cycle: expiry wins and the press is dropped (neither score nor misses change).
- Start edge during LOAD or PLAY is ignored.
- Presses in IDLE, LOAD and DONE are discarded.
- rst_n low mid-round aborts immediately to the reset values.

Latency: press pulse to enable/score/misses update is 1 cycle.

Optional Feature:
MISS_PENALTY_EN
- Defined: each miss in PLAY also subtracts 1 from secs_left, floored at 0.
  - Reaching 0 this way moves to DONE on the same edge.
  - A miss and a one_hz edge in the same cycle subtract 2 (floored at 0).
- Not defined: misses do not affect the timer.

Test Plan:
(all with DEBOUNCE_CYCLES=4, ROUND_SECS=3)
- Reset then start edge with rand_*=1,2,3,4 -> LOAD latches digits 1,2,3,4, enables all 1, secs_left=3.
- Type 1,2,3,4, each held 6 cycles with 6-cycle gaps -> one_en..four_en clear in order; after key 4, score=1, a new word is latched and all enables=1.
- Press key 7 when 1 is expected -> misses=1, one_en stays 1, pos unchanged; with MISS_PENALTY_EN, secs_left drops 3->2.
- key_level pulses high 3 cycles, then low -> no press registered, misses and enables unchanged. Holding the key 40 cycles -> exactly one press registered.
- Three one_hz rising edges -> secs_left 3,2,1,0; done=1, digit_three/digit_four show score, all enables=1. A press on the expiry cycle is ignored.
- rst_n=0 for 1 cycle mid-PLAY -> IDLE, all enables 0, score=0, misses=0, done=0.
